userio_seq: RTL and testbench

//  Sequencer and owner-arbiter for the USERIO bit-bang pins. It feeds I_userio_drive_data and
//  I_userio_pwdriven of the USERIO pad block. When idle, the pins follow static host register

---
 rtl/userio_seq_pkg.sv | 31 +++
 rtl/userio_seq_if.sv | 34 +++
 rtl/userio_seq_tbl.sv | 35 +++
 rtl/userio_seq.sv | 207 ++++++++++++++++++++
 tb/tb_userio_seq.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/userio_seq_pkg.sv
// Shared types and table-entry layout for the USERIO pattern sequencer.
// An entry is packed as {hold, oe, data}, with data in the least significant bits.
package userio_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_HOLDW = 16;

    localparam int DATA_LSB = 0;
    localparam int OE_LSB   = DEF_WIDTH;
    localparam int HOLD_LSB = 2 * DEF_WIDTH;

    function automatic int entryWidth(input int width, input int holdW);
        return 2 * width + holdW;
    endfunction

    function automatic int oeLsb(input int width);
        return width;
    endfunction

    function automatic int holdLsb(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/userio_seq_if.sv
// Host-side register bus of the USERIO sequencer: table writes, run control, static pin values and status.
interface userio_seq_if #(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 16,
    parameter int pHOLDW = 16,
    parameter int pLOOPW = 8
) ();
    localparam int pAW = $clog2(pDEPTH);

    logic                       tbl_we;
    logic [pAW-1:0]             tbl_addr;
    logic [2*pWIDTH+pHOLDW-1:0] tbl_wdata;
    logic [pAW:0]               seq_len;
    logic [pLOOPW-1:0]          seq_loops;
    logic                       start;
    logic                       stop;
    logic [pWIDTH-1:0]          host_data;
    logic [pWIDTH-1:0]          host_oe;
    logic                       busy;
    logic                       done;
    logic [pAW-1:0]             step_idx;
    logic                       tbl_wr_err;

    modport master (
        output tbl_we, tbl_addr, tbl_wdata, seq_len, seq_loops, start, stop, host_data, host_oe,
        input  busy, done, step_idx, tbl_wr_err
    );

    modport slave (
        input  tbl_we, tbl_addr, tbl_wdata, seq_len, seq_loops, start, stop, host_data, host_oe,
        output busy, done, step_idx, tbl_wr_err
    );

endinterface

// File: rtl/userio_seq_tbl.sv
// Pattern table: simple dual-port RAM, synchronous write and registered read.
// Contents have no reset so the array maps onto LUTRAM or block RAM.
module userio_seq_tbl #(
    parameter int pDEPTH = 16,
    parameter int pEW    = 32,
    parameter int pAW    = $clog2(pDEPTH)
) (
    input  logic           clk,
    input  logic           i_we,
    input  logic [pAW-1:0] i_waddr,
    input  logic [pEW-1:0] i_wdata,
    input  logic           i_re,
    input  logic [pAW-1:0] i_raddr,
    output logic [pEW-1:0] o_rdata
);

    logic [pEW-1:0] r_mem [pDEPTH];
    logic [pEW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register only moves on a fetch, so the entry stays stable for the whole step.
    always_ff @(posedge clk) begin
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/userio_seq.sv
// USERIO pin sequencer and owner arbiter: host static values when idle, table replay when running.
// Optional pin capture at the end of each step is enabled by defining USERIO_SEQ_CAPTURE_EN.
module userio_seq
    import userio_seq_pkg::*;
#(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 16,
    parameter int pHOLDW = 16,
    parameter int pLOOPW = 8
) (
    input  logic              usb_clk,
    input  logic              reset_n,
    userio_seq_if.slave       bus,
    output logic [pWIDTH-1:0] o_userio_drive_data,
    output logic [pWIDTH-1:0] o_userio_pwdriven
`ifdef USERIO_SEQ_CAPTURE_EN
    ,
    input  logic [pWIDTH-1:0] i_userio_sample,
    output logic [pWIDTH-1:0] o_cap_data,
    output logic              o_cap_valid
`endif
);

    localparam int pAW      = $clog2(pDEPTH);
    localparam int pEW      = entryWidth(pWIDTH, pHOLDW);
    localparam int OE_OFS   = oeLsb(pWIDTH);
    localparam int HOLD_OFS = holdLsb(pWIDTH);

    state_t            r_state;
    state_t            w_nextState;
    logic [pAW-1:0]    r_stepIdx;
    logic [pLOOPW-1:0] r_passCnt;
    logic [pHOLDW-1:0] r_holdCnt;
    logic [pAW:0]      r_seqLen;
    logic [pLOOPW-1:0] r_seqLoops;
    logic [pWIDTH-1:0] r_outData;
    logic [pWIDTH-1:0] r_outOe;
    logic              r_zeroDone;
    logic              r_wrErr;

    logic [pEW-1:0]    w_rdEntry;
    logic [pWIDTH-1:0] w_entryData;
    logic [pWIDTH-1:0] w_entryOe;
    logic [pHOLDW-1:0] w_entryHold;
    logic [pAW:0]      w_seqLenSat;
    logic              w_startReq;
    logic              w_lastHold;
    logic              w_stepMore;
    logic              w_passMore;
    logic              w_busy;
    logic              w_done;
    logic              w_tblWe;
    logic              w_tblRe;

    assign w_entryData = w_rdEntry[DATA_LSB +: pWIDTH];
    assign w_entryOe   = w_rdEntry[OE_OFS +: pWIDTH];
    assign w_entryHold = w_rdEntry[HOLD_OFS +: pHOLDW];

    assign w_seqLenSat = (bus.seq_len > (pAW+1)'(pDEPTH)) ? (pAW+1)'(pDEPTH) : bus.seq_len;
    // Stop has priority, so a coincident start/stop never launches a run.
    assign w_startReq  = bus.start & ~bus.stop;
    assign w_lastHold  = (r_state == HOLD) && (r_holdCnt == w_entryHold);
    assign w_stepMore  = (({1'b0, r_stepIdx} + (pAW+1)'(1)) < r_seqLen);
    assign w_passMore  = (r_seqLoops == '0) ||
                         (({1'b0, r_passCnt} + (pLOOPW+1)'(1)) < {1'b0, r_seqLoops});

    userio_seq_tbl #(
        .pDEPTH (pDEPTH),
        .pEW    (pEW),
        .pAW    (pAW)
    ) u_tbl (
        .clk     (usb_clk),
        .i_we    (w_tblWe),
        .i_waddr (bus.tbl_addr),
        .i_wdata (bus.tbl_wdata),
        .i_re    (w_tblRe),
        .i_raddr (r_stepIdx),
        .o_rdata (w_rdEntry)
    );

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_busy      = 1'b0;
        w_done      = r_zeroDone;
        w_tblRe     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startReq && (w_seqLenSat != '0)) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_busy      = 1'b1;
                w_tblRe     = 1'b1;
                w_nextState = bus.stop ? IDLE : HOLD;
            end
            HOLD: begin
                w_busy = 1'b1;
                if (bus.stop) begin
                    w_nextState = IDLE;
                end else if (w_lastHold) begin
                    w_nextState = (w_stepMore || w_passMore) ? FETCH : DONE;
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
        w_tblWe = bus.tbl_we & ~w_busy;
    end

    // Step, pass and hold counters; run parameters are latched at start so host edits cannot disturb a run.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stepIdx  <= '0;
            r_passCnt  <= '0;
            r_holdCnt  <= '0;
            r_seqLen   <= '0;
            r_seqLoops <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_nextState == FETCH) begin
                        r_stepIdx  <= '0;
                        r_passCnt  <= '0;
                        r_seqLen   <= w_seqLenSat;
                        r_seqLoops <= bus.seq_loops;
                    end
                end
                FETCH: begin
                    r_holdCnt <= '0;
                end
                HOLD: begin
                    if (!w_lastHold) begin
                        r_holdCnt <= r_holdCnt + pHOLDW'(1);
                    end else if (!bus.stop) begin
                        if (w_stepMore) begin
                            r_stepIdx <= r_stepIdx + pAW'(1);
                        end else begin
                            r_stepIdx <= '0;
                            r_passCnt <= r_passCnt + pLOOPW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Pin holding register: tracks the host when heading to IDLE, otherwise keeps the last entry between steps.
    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_outData  <= '0;
            r_outOe    <= '0;
            r_zeroDone <= 1'b0;
            r_wrErr    <= 1'b0;
        end else begin
            if (w_nextState == IDLE) begin
                r_outData <= bus.host_data;
                r_outOe   <= bus.host_oe;
            end else if (r_state == HOLD) begin
                r_outData <= w_entryData;
                r_outOe   <= w_entryOe;
            end
            r_zeroDone <= (r_state == IDLE) && w_startReq && (w_seqLenSat == '0);
            r_wrErr    <= bus.tbl_we & w_busy;
        end
    end

    assign o_userio_drive_data = (r_state == HOLD) ? w_entryData : r_outData;
    assign o_userio_pwdriven   = (r_state == HOLD) ? w_entryOe   : r_outOe;

    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.step_idx   = r_stepIdx;
    assign bus.tbl_wr_err = r_wrErr;

`ifdef USERIO_SEQ_CAPTURE_EN
    logic [pWIDTH-1:0] r_capData;

    always_ff @(posedge usb_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_capData <= '0;
        end else if (w_lastHold) begin
            r_capData <= i_userio_sample;
        end
    end

    // The sample is visible in the same cycle as the strobe and held afterwards.
    assign o_cap_valid = w_lastHold;
    assign o_cap_data  = w_lastHold ? i_userio_sample : r_capData;
`endif

endmodule

// File: tb/tb_userio_seq.sv
// Self-checking bench for userio_seq: table-driven idle and timing vectors, hand sequences
// for stop/reset/write-while-busy, and randomized runs against a step-list reference model.
module tb_userio_seq;

    localparam int pWIDTH = 8;
    localparam int pDEPTH = 16;
    localparam int pHOLDW = 16;
    localparam int pLOOPW = 8;

    typedef struct {
        logic       busy;
        logic       done;
        logic       chkData;
        logic [7:0] data;
        logic [7:0] oe;
        logic       chkStep;
        logic [3:0] step;
    } expRec_t;

    typedef struct {
        logic [7:0] hostData;
        logic [7:0] hostOe;
        logic [7:0] expData;
        logic [7:0] expOe;
    } idleVec_t;

    typedef struct {
        logic       busy;
        logic       done;
        logic       chkData;
        logic [7:0] data;
        logic       capValid;
    } timeVec_t;

    logic usb_clk = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] driveData;
    logic [7:0] pwDriven;
`ifdef USERIO_SEQ_CAPTURE_EN
    logic [7:0] userioSample;
    logic [7:0] capData;
    logic       capValid;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] tblModel [pDEPTH];

    always #5 usb_clk = ~usb_clk;

    userio_seq_if #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH), .pHOLDW(pHOLDW), .pLOOPW(pLOOPW)) bus ();

    userio_seq #(.pWIDTH(pWIDTH), .pDEPTH(pDEPTH), .pHOLDW(pHOLDW), .pLOOPW(pLOOPW)) dut (
        .usb_clk             (usb_clk),
        .reset_n             (reset_n),
        .bus                 (bus),
        .o_userio_drive_data (driveData),
        .o_userio_pwdriven   (pwDriven)
`ifdef USERIO_SEQ_CAPTURE_EN
        ,
        .i_userio_sample     (userioSample),
        .o_cap_data          (capData),
        .o_cap_valid         (capValid)
`endif
    );

    task automatic tick();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] hd, input logic [7:0] ho, input logic st, input logic sp);
        bus.host_data = hd;
        bus.host_oe   = ho;
        bus.start     = st;
        bus.stop      = sp;
    endtask

    task automatic writeEntry(input logic [3:0] a, input logic [7:0] d, input logic [7:0] o, input logic [15:0] h);
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = a;
        bus.tbl_wdata = {h, o, d};
        tick();
        bus.tbl_we    = 1'b0;
        tblModel[a]   = {h, o, d};
    endtask

    // Reference model: each step is one fetch cycle plus hold+1 cycles showing the entry.
    task automatic runSeq(input int len, input int loops, input int stopAt, input logic [7:0] hd, input logic [7:0] ho);
        expRec_t q[$];
        expRec_t r;
        logic [31:0] e;
        int effLen = (len > pDEPTH) ? pDEPTH : len;
        int passes = (loops == 0) ? 3 : loops;
        if (effLen == 0) begin
            r = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0};
            q.push_back(r);
        end else begin
            for (int p = 0; p < passes; p++) begin
                for (int s = 0; s < effLen; s++) begin
                    e = tblModel[s];
                    r = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 4'(s)};
                    q.push_back(r);
                    for (int k = 0; k <= int'(e[31:16]); k++) begin
                        r.chkData = 1'b1;
                        r.data    = e[7:0];
                        r.oe      = e[15:8];
                        q.push_back(r);
                    end
                end
            end
            if (loops != 0) begin
                r = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0};
                q.push_back(r);
            end
        end
        if (loops != 0 || effLen == 0) begin
            r = '{1'b0, 1'b0, 1'b1, hd, ho, 1'b0, 4'h0};
            q.push_back(r);
        end

        bus.seq_len   = 5'(len);
        bus.seq_loops = 8'(loops);
        applyStimulus(hd, ho, 1'b1, 1'b0);
        tick();
        applyStimulus(hd, ho, 1'b0, 1'b0);
        for (int i = 0; i < q.size(); i++) begin
            if (i == stopAt) begin
                applyStimulus(hd, ho, 1'b0, 1'b1);
                tick();
                applyStimulus(hd, ho, 1'b0, 1'b0);
                checkOutput("stop_busy", 32'(bus.busy), 0);
                checkOutput("stop_done", 32'(bus.done), 0);
                checkOutput("stop_data", 32'(driveData), 32'(hd));
                checkOutput("stop_oe", 32'(pwDriven), 32'(ho));
                tick();
                checkOutput("stop_nodone", 32'(bus.done), 0);
                return;
            end
            checkOutput("seq_busy", 32'(bus.busy), 32'(q[i].busy));
            checkOutput("seq_done", 32'(bus.done), 32'(q[i].done));
            if (q[i].chkData) begin
                checkOutput("seq_data", 32'(driveData), 32'(q[i].data));
                checkOutput("seq_oe", 32'(pwDriven), 32'(q[i].oe));
            end
            if (q[i].chkStep) begin
                checkOutput("seq_step", 32'(bus.step_idx), 32'(q[i].step));
            end
            if (i < q.size() - 1) begin
                tick();
            end
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        idleVec_t iv [4];
        timeVec_t tv [8];
        int len;
        int loops;
        logic [7:0] hd;
        logic [7:0] ho;

        iv[0] = '{8'hA5, 8'h0F, 8'hA5, 8'h0F};
        iv[1] = '{8'h5A, 8'hF0, 8'h5A, 8'hF0};
        iv[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        iv[3] = '{8'h00, 8'hFF, 8'h00, 8'hFF};

        tv[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[1] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        tv[2] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b0};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1};
        tv[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
        tv[5] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1};
        tv[6] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tv[7] = '{1'b0, 1'b0, 1'b1, 8'h77, 1'b0};

        bus.tbl_we    = 1'b0;
        bus.tbl_addr  = '0;
        bus.tbl_wdata = '0;
        bus.seq_len   = '0;
        bus.seq_loops = '0;
        applyStimulus(8'h00, 8'h00, 1'b0, 1'b0);
`ifdef USERIO_SEQ_CAPTURE_EN
        userioSample = 8'h3C;
`endif

        #12;
        checkOutput("rst_data", 32'(driveData), 0);
        checkOutput("rst_oe", 32'(pwDriven), 0);
        checkOutput("rst_busy", 32'(bus.busy), 0);
        checkOutput("rst_done", 32'(bus.done), 0);
        checkOutput("rst_step", 32'(bus.step_idx), 0);
        checkOutput("rst_wrerr", 32'(bus.tbl_wr_err), 0);
        reset_n = 1'b1;
        tick();

        $display("[TB] idle passthrough");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(iv[i].hostData, iv[i].hostOe, 1'b0, 1'b0);
            tick();
            checkOutput("idle_data", 32'(driveData), 32'(iv[i].expData));
            checkOutput("idle_oe", 32'(pwDriven), 32'(iv[i].expOe));
        end

        $display("[TB] two-step timing");
        writeEntry(4'd0, 8'h01, 8'hFF, 16'd2);
        checkOutput("idle_wrerr", 32'(bus.tbl_wr_err), 0);
        writeEntry(4'd1, 8'h02, 8'hFF, 16'd0);
        bus.seq_len   = 5'd2;
        bus.seq_loops = 8'd1;
        applyStimulus(8'h77, 8'h55, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h77, 8'h55, 1'b0, 1'b0);
        for (int t = 0; t < 8; t++) begin
            checkOutput("t3_busy", 32'(bus.busy), 32'(tv[t].busy));
            checkOutput("t3_done", 32'(bus.done), 32'(tv[t].done));
            if (tv[t].chkData) begin
                checkOutput("t3_data", 32'(driveData), 32'(tv[t].data));
            end
`ifdef USERIO_SEQ_CAPTURE_EN
            checkOutput("cap_valid", 32'(capValid), 32'(tv[t].capValid));
            if (tv[t].capValid) begin
                checkOutput("cap_data", 32'(capData), 32'h3C);
            end
`endif
            if (t < 7) begin
                tick();
            end
        end
        tick();

        $display("[TB] endless loop with stop");
        runSeq(2, 0, int'($urandom_range(1, 12)), 8'h33, 8'hC3);
        tick();

        $display("[TB] write while busy");
        bus.seq_len   = 5'd2;
        bus.seq_loops = 8'd1;
        applyStimulus(8'h33, 8'hC3, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h33, 8'hC3, 1'b0, 1'b0);
        tick();
        bus.tbl_we    = 1'b1;
        bus.tbl_addr  = 4'd1;
        bus.tbl_wdata = {16'd0, 8'h00, 8'hEE};
        tick();
        bus.tbl_we    = 1'b0;
        checkOutput("wrerr_pulse", 32'(bus.tbl_wr_err), 1);
        tick();
        checkOutput("wrerr_clear", 32'(bus.tbl_wr_err), 0);
        for (int n = 0; n < 50 && bus.busy; n++) begin
            tick();
        end
        checkOutput("drain_busy", 32'(bus.busy), 0);
        tick();
        tick();
        runSeq(2, 1, -1, 8'h33, 8'hC3);
        tick();

        $display("[TB] zero length and start+stop");
        runSeq(0, 1, -1, 8'h44, 8'h0F);
        tick();
        bus.seq_len = 5'd2;
        applyStimulus(8'h44, 8'h0F, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h44, 8'h0F, 1'b0, 1'b0);
        checkOutput("ss_busy", 32'(bus.busy), 0);
        tick();
        checkOutput("ss_busy2", 32'(bus.busy), 0);
        checkOutput("ss_done", 32'(bus.done), 0);

        $display("[TB] reset mid-hold");
        bus.seq_len   = 5'd1;
        bus.seq_loops = 8'd1;
        applyStimulus(8'h44, 8'h0F, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h44, 8'h0F, 1'b0, 1'b0);
        tick();
        checkOutput("hold_data", 32'(driveData), 32'h01);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("arst_data", 32'(driveData), 0);
        checkOutput("arst_oe", 32'(pwDriven), 0);
        checkOutput("arst_busy", 32'(bus.busy), 0);
        #1 reset_n = 1'b1;
        tick();
        tick();

        $display("[TB] randomized runs");
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < pDEPTH; a++) begin
                writeEntry(4'(a), 8'($urandom), 8'($urandom), 16'($urandom_range(0, 3)));
            end
            len   = int'($urandom_range(0, 20));
            loops = int'($urandom_range(1, 3));
            hd    = 8'($urandom);
            ho    = 8'($urandom);
            runSeq(len, loops, -1, hd, ho);
            tick();
            len = int'($urandom_range(1, 16));
            runSeq(len, 0, int'($urandom_range(1, 2 * len)), hd, ho);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
